// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage around the 32-bit alu with a small result buffer,
// a status word of the last pushed flags and a completed-op counter.
// Optional feature macro: ALU_STICKY_OVF_EN (sticky overflow bit psw_sov, cleared by clr_sov).

// Combinational 32-bit alu; flags are {negative, zero, carry, overflow} at the stage level.
// carry is the unsigned carry-out for adds and the borrow for subtracts / SLTU.
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] result,
  output logic        zero,
  output logic        carry,
  output logic        negative,
  output logic        overflow
);

  logic [32:0] w_sum;
  logic [32:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  // Opcode decode: 0000 ADDU, 0010 ADD, 0001 SUBU, 0011 SUB, 01xx logic, 100x LUI,
  // 1010 SLTU, 1011 SLT, 1100 SRA, 1101 SRL, 111x SLL (shift amount a[4:0], value b).
  always_comb begin
    result   = 32'h0000_0000;
    carry    = 1'b0;
    overflow = 1'b0;
    case (aluc)
      4'b0000: begin
        result = w_sum[31:0];
        carry  = w_sum[32];
      end
      4'b0010: begin
        result   = w_sum[31:0];
        carry    = w_sum[32];
        overflow = (a[31] == b[31]) && (w_sum[31] != a[31]);
      end
      4'b0001: begin
        result = w_diff[31:0];
        carry  = w_diff[32];
      end
      4'b0011: begin
        result   = w_diff[31:0];
        carry    = w_diff[32];
        overflow = (a[31] != b[31]) && (w_diff[31] != a[31]);
      end
      4'b0100: result = a & b;
      4'b0101: result = a | b;
      4'b0110: result = a ^ b;
      4'b0111: result = ~(a | b);
      4'b1000,
      4'b1001: result = {b[15:0], 16'h0000};
      4'b1010: begin
        result = {31'b0, w_diff[32]};
        carry  = w_diff[32];
      end
      4'b1011: result = {31'b0, ($signed(a) < $signed(b))};
      4'b1100: result = $signed(b) >>> a[4:0];
      4'b1101: result = b >> a[4:0];
      default: result = b << a[4:0];
    endcase
  end

  assign zero     = (result == 32'h0000_0000);
  assign negative = result[31];

endmodule

module alu_exec_stage #(
  parameter int unsigned RD_W  = 5,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [3:0]       in_aluc,
  input  logic [RD_W-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic [RD_W-1:0]  out_rd,
  output logic [3:0]       psw,
  output logic [CNT_W-1:0] op_count
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic             clr_sov,
  output logic             psw_sov
`endif
);

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W    = $clog2(DEPTH + 1);
  localparam int unsigned FLAGS_W  = 4;

  logic [31:0]        r_slot_res [DEPTH];
  logic [FLAGS_W-1:0] r_slot_fl  [DEPTH];
  logic [RD_W-1:0]    r_slot_rd  [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]   r_count;
  logic [FLAGS_W-1:0] r_psw;
  logic [CNT_W-1:0]   r_op_count;

  logic [31:0]        w_result;
  logic               w_zero;
  logic               w_carry;
  logic               w_negative;
  logic               w_overflow;
  logic [FLAGS_W-1:0] w_flags;
  logic               w_push;
  logic               w_pop;

  alu u_alu (
    .a        (in_a),
    .b        (in_b),
    .aluc     (in_aluc),
    .result   (w_result),
    .zero     (w_zero),
    .carry    (w_carry),
    .negative (w_negative),
    .overflow (w_overflow)
  );

  assign w_flags   = {w_negative, w_zero, w_carry, w_overflow};
  assign in_ready  = (r_count != OCC_W'(DEPTH));
  assign out_valid = (r_count != OCC_W'(0));
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign out_result = r_slot_res[r_rd_ptr];
  assign out_flags  = r_slot_fl[r_rd_ptr];
  assign out_rd     = r_slot_rd[r_rd_ptr];
  assign psw        = r_psw;
  assign op_count   = r_op_count;

  // Result buffer, pointers, occupancy, status word and pop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_slot_res[i] <= '0;
        r_slot_fl[i]  <= '0;
        r_slot_rd[i]  <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_psw      <= '0;
      r_op_count <= '0;
    end else begin
      if (w_push) begin
        r_slot_res[r_wr_ptr] <= w_result;
        r_slot_fl[r_wr_ptr]  <= w_flags;
        r_slot_rd[r_wr_ptr]  <= in_rd;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
        r_psw    <= w_flags;
      end
      if (w_pop) begin
        r_rd_ptr   <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
        r_op_count <= r_op_count + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic r_sov;

  assign psw_sov = r_sov;

  // Sticky overflow: a pushed overflow sets it and beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sov <= 1'b0;
    end else if (w_push && w_overflow) begin
      r_sov <= 1'b1;
    end else if (clr_sov) begin
      r_sov <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: queue-based reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_alu_exec_stage;

  localparam int unsigned RD_W  = 5;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 6;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [3:0]       in_aluc = '0;
  logic [RD_W-1:0]  in_rd = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [3:0]       out_flags;
  logic [RD_W-1:0]  out_rd;
  logic [3:0]       psw;
  logic [CNT_W-1:0] op_count;
`ifdef ALU_STICKY_OVF_EN
  logic             clr_sov = 1'b0;
  logic             psw_sov;
`endif

  always #5 clk = ~clk;

  alu_exec_stage #(.RD_W(RD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_aluc    (in_aluc),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_rd     (out_rd),
    .psw        (psw),
    .op_count   (op_count)
`ifdef ALU_STICKY_OVF_EN
    ,
    .clr_sov    (clr_sov),
    .psw_sov    (psw_sov)
`endif
  );

  typedef struct packed {
    logic [31:0]     res;
    logic [3:0]      fl;
    logic [RD_W-1:0] rd;
  } ent_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t mq[$];
  logic [3:0] m_psw = '0;
  int   m_cnt = 0;
  bit   m_live = 1'b0;
  bit   m_sov = 1'b0;
  bit   m_dp;
  bit   m_dq;
  ent_t m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference alu in plain integer arithmetic; flags {negative, zero, carry/borrow, overflow}.
  function automatic ent_t m_alu(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic [RD_W-1:0] rd);
    longint ua, ub, sa, sb, t;
    logic [31:0] r;
    logic c, v;
    ent_t e;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'b0000, 4'b0010: begin
        r = a + b;
        t = ua + ub;
        c = (t > 64'sd4294967295);
        if (op == 4'b0010) begin
          t = sa + sb;
          v = (t > SMAX) || (t < SMIN);
        end
      end
      4'b0001, 4'b0011: begin
        r = a - b;
        c = (ua < ub);
        if (op == 4'b0011) begin
          t = sa - sb;
          v = (t > SMAX) || (t < SMIN);
        end
      end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1000, 4'b1001: r = b * 32'd65536;
      4'b1010: begin c = (ua < ub); r = c ? 32'd1 : 32'd0; end
      4'b1011: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: begin t = sb >>> a[4:0]; r = t[31:0]; end
      4'b1101: r = b >> a[4:0];
      default: r = b << a[4:0];
    endcase
    e.res = r;
    e.fl  = {r[31], (r == 32'd0), c, v};
    e.rd  = rd;
    return e;
  endfunction

  // Reference model: advances on each rising edge from the bench's own view of the inputs.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_psw  = '0;
      m_cnt  = 0;
      m_sov  = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_dp = in_valid && (mq.size() < int'(DEPTH));
      m_dq = out_ready && (mq.size() > 0);
      if (m_dq) begin
        void'(mq.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      if (m_dp) begin
        m_e = m_alu(in_a, in_b, in_aluc, in_rd);
        mq.push_back(m_e);
        m_psw = m_e.fl;
      end
`ifdef ALU_STICKY_OVF_EN
      if (m_dp && m_e.fl[0]) m_sov = 1'b1;
      else if (clr_sov)      m_sov = 1'b0;
`endif
    end
  end

  // Compare DUT against the model between edges.
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() < int'(DEPTH)));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_result", out_result, mq[0].res);
        chk("out_flags", 32'(out_flags), 32'(mq[0].fl));
        chk("out_rd", 32'(out_rd), 32'(mq[0].rd));
      end
      chk("psw", 32'(psw), 32'(m_psw));
      chk("op_count", 32'(op_count), 32'(m_cnt));
`ifdef ALU_STICKY_OVF_EN
      chk("psw_sov", 32'(psw_sov), 32'(m_sov));
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [RD_W-1:0] rd);
    in_a = a; in_b = b; in_aluc = op; in_rd = rd;
  endtask

  // Present one token, waiting (bounded) for in_ready, then drop valid.
  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [RD_W-1:0] rd);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_wait: in_ready stayed 0 expected 1 at %0t", $time);
    end
    set_in(a, b, op, rd);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic head_is(input string name, input logic [31:0] res, input logic [3:0] fl,
                         input logic [RD_W-1:0] rd);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_res"}, out_result, res);
    chk({name, "_flags"}, 32'(out_flags), 32'(fl));
    chk({name, "_rd"}, 32'(out_rd), 32'(rd));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'd5,          32'd7,          4'b0011, 32'hFFFF_FFFE, 4'b1010};
    vecs[1] = '{32'h8000_0000,  32'd1,          4'b0011, 32'h7FFF_FFFF, 4'b0001};
    vecs[2] = '{32'hFFFF_FFFF,  32'd1,          4'b1011, 32'd1,         4'b0000};
    vecs[3] = '{32'd0,          32'h0000_1234,  4'b1000, 32'h1234_0000, 4'b0000};
    vecs[4] = '{32'd4,          32'h8000_0000,  4'b1100, 32'hF800_0000, 4'b1000};
    vecs[5] = '{32'hFFFF_FFFF,  32'd1,          4'b0000, 32'd0,         4'b0110};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_psw", 32'(psw), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    rst = 1'b0;
    tick();

    // Basic signed add, visible the next cycle
    out_ready = 1'b0;
    push(32'd32, 32'd64, 4'b0010, 5'd3);
    head_is("t1", 32'd96, 4'b0000, 5'd3);
    chk("t1_psw", 32'(psw), 32'd0);

    // Signed overflow pushed while the previous entry pops (count stays 1)
    out_ready = 1'b1;
    push(32'h7FFF_FFFF, 32'd1, 4'b0010, 5'd4);
    head_is("t2", 32'h8000_0000, 4'b1001, 5'd4);
    chk("t2_psw", 32'(psw), 32'h9);
    chk("t2_op_count", 32'(op_count), 32'd1);
    tick();
    chk("t2_drained", 32'(out_valid), 32'd0);
    chk("t2_op_count2", 32'(op_count), 32'd2);

    // Back-to-back pushes into a stalled output: third is held off until a pop
    out_ready = 1'b0;
    push(32'd1, 32'd2, 4'b0000, 5'd5);
    push(32'd3, 32'd10, 4'b0001, 5'd6);
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    set_in(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0010, 5'd9);
    tick();
    set_in(32'd100, 32'd200, 4'b0101, 5'd7);
    tick();
    chk("t3_hold_res", out_result, 32'd3);
    chk("t3_hold_psw", 32'(psw), 32'hA);
    chk("t3_hold_cnt", 32'(op_count), 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_freed_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    head_is("t3_h2", 32'hFFFF_FFF9, 4'b1010, 5'd6);
    chk("t3_cnt3", 32'(op_count), 32'd3);
    out_ready = 1'b1;
    tick();
    head_is("t3_h3", 32'h0000_00EC, 4'b0000, 5'd7);
    tick();
    chk("t3_empty", 32'(out_valid), 32'd0);
    chk("t3_cnt5", 32'(op_count), 32'd5);

    // Push and pop together at count 1
    out_ready = 1'b0;
    push(32'd8, 32'd8, 4'b0110, 5'd10);
    out_ready = 1'b1;
    push(32'd1, 32'd1, 4'b1110, 5'd11);
    head_is("t4", 32'd2, 4'b0000, 5'd11);
    chk("t4_ready", 32'(in_ready), 32'd1);
    chk("t4_cnt", 32'(op_count), 32'd6);
    tick();

    // Reset with two entries buffered and a handshake pending
    out_ready = 1'b0;
    push(32'd11, 32'd22, 4'b0000, 5'd1);
    push(32'd33, 32'd44, 4'b0000, 5'd2);
    chk("t5_full", 32'(in_ready), 32'd0);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_psw", 32'(psw), 32'd0);
    chk("t5_op_count", 32'(op_count), 32'd0);
    chk("t5_out_result", out_result, 32'd0);

    // Opcode table with literal expectations
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].op, 5'(i));
      head_is($sformatf("op%0d", i), vecs[i].res, vecs[i].fl, 5'(i));
    end
    tick();

    // Mixed traffic; long enough for op_count to wrap
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_in($urandom(), (i % 7 == 0) ? 32'h8000_0000 : $urandom(), 4'($urandom_range(0, 15)), 5'(i));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick(); tick();

`ifdef ALU_STICKY_OVF_EN
    // Sticky overflow: set, held, cleared, and set beating clear
    out_ready = 1'b1;
    clr_sov = 1'b1;
    tick();
    clr_sov = 1'b0;
    chk("sov_clr0", 32'(psw_sov), 32'd0);
    push(32'h7FFF_FFFF, 32'd1, 4'b0010, 5'd1);
    chk("sov_set", 32'(psw_sov), 32'd1);
    push(32'd1, 32'd1, 4'b0010, 5'd2);
    chk("sov_held", 32'(psw_sov), 32'd1);
    clr_sov = 1'b1;
    tick();
    chk("sov_clr", 32'(psw_sov), 32'd0);
    push(32'h8000_0000, 32'h8000_0000, 4'b0010, 5'd3);
    clr_sov = 1'b0;
    chk("sov_set_wins", 32'(psw_sov), 32'd1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
